mc_cpu: RTL and testbench
=========================

MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 The module SHALL have the following parameters:
  - DATA_W, default 32: register/ALU/data-memory width, legal 16..64.
  - ADDR_W, default 16: PC and memory address width, word-addressed.
  - NREG, default 32: register count, power of 2, 2..32.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1: clock.
  - reset, in, 1: asynchronous, active-high reset.
  - imem_req, out, 1: fetch request.
  - imem_addr, out, ADDR_W: fetch address; equals pc.
  - imem_rdata, in, 32: instruction word.
  - imem_ready, in, 1: fetch accept; instruction is valid on imem_rdata.
  - dmem_req, out, 1: data request.
  - dmem_we, out, 1: 1 = store, 0 = load.
  - dmem_addr, out, ADDR_W: data address; ALU result truncated or zero-extended to ADDR_W.
  - dmem_wdata, out, DATA_W: store data.
  - dmem_rdata, in, DATA_W: load data.
  - dmem_ready, in, 1: data accept/valid.
  - pc, out, ADDR_W: current PC.
  - halted, out, 1: illegal instruction trapped.
  - instret, out, 32: retired-instruction count.

Function
REQ-003 The core SHALL be a multi-cycle, non-pipelined processor with states FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
REQ-004 The core SHALL support these instructions:
  - R-type (op 000000) with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed).
  - addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
REQ-005 FETCH SHALL assert imem_req with imem_addr=pc held stable until imem_ready=1 is sampled at a clock edge. At that edge: IR<=imem_rdata, pc<=pc+1 (modulo 2^ADDR_W), next state DECODE.
REQ-006 DECODE SHALL latch A=R[rs] and B=R[rt], and select the next state by opcode:
  - R-type/addi -> EXEC.
  - lw/sw -> MEM_ADDR.
  - beq -> BRANCH.
  - j -> JUMP.
  - unknown opcode, or unknown funct with R-type -> HALT.
REQ-007 The immediate SHALL be IR[15:0] sign-extended to DATA_W for addi/lw/sw, and sign-extended to ADDR_W for beq.
REQ-008 EXEC SHALL latch ALUOut and go to ALU_WB. ALU_WB SHALL write R[rd] (R-type) or R[rt] (addi), then go to FETCH.
REQ-009 MEM_ADDR SHALL compute ALUOut=A+imm and go to MEM_RD (lw) or MEM_WR (sw).
REQ-010 MEM_RD/MEM_WR SHALL hold dmem_req=1, dmem_we (0/1), dmem_addr and dmem_wdata=B stable until dmem_ready=1 is sampled. MEM_RD SHALL then latch MDR<=dmem_rdata and go to MEM_WB; MEM_WR SHALL go to FETCH.
REQ-011 MEM_WB SHALL write R[rt]=MDR, then go to FETCH.
REQ-012 BRANCH SHALL set pc<=pc+imm when A==B (pc already holds PC+1), then go to FETCH.
REQ-013 JUMP SHALL set pc<=IR[25:0] truncated or zero-extended to ADDR_W, then go to FETCH.
REQ-014 Cycle counts with ready high on first request: R/addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle on a ready signal SHALL add exactly one cycle.
REQ-015 R0 SHALL always read 0; writes to R0 SHALL be discarded. Register indices SHALL use the low log2(NREG) bits of the instruction field.
REQ-016 instret SHALL increment by 1 on the final cycle of each instruction and wrap from 2^32-1 to 0.
REQ-017 HALT SHALL be terminal until reset: halted=1, no requests, pc and instret frozen.
REQ-018 imem_req and dmem_req SHALL never be asserted in the same cycle. Both SHALL be 0 in all states other than FETCH, MEM_RD and MEM_WR.
REQ-019 Arithmetic SHALL be modulo 2^DATA_W with no overflow trap.

Reset
REQ-020 Asserting reset SHALL immediately, in any state including mid-handshake, force state=FETCH, pc=0, IR/A/B/ALUOut/MDR=0, all registers=0, instret=0, halted=0, and both req signals=0.
REQ-021 The first imem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-022 Package mc_cpu_pkg SHALL hold the opcode and funct constants, the state enum and the ALU-operation enum.
REQ-023 The register file SHALL be the sub-module mc_regfile (parameters DATA_W and NREG; 2 asynchronous read ports, 1 synchronous write port, R0 hardwired to zero, asynchronous reset).

Verification
REQ-024 Directed scenarios (defaults, ready tied high unless stated):
  - addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r3=2; instret=3 after 12 cycles.
  - sw r1,4(r0) then lw r4,4(r0) -> dmem write of addr 4 data 5; r4=5; lw takes 5 cycles.
  - dmem_ready held low 3 cycles during lw -> lw takes 8 cycles; dmem_addr/dmem_we/dmem_req stable throughout.
  - beq r1,r1,-1 at pc=7 -> pc returns to 7 (loop); beq not taken -> pc=8; j 0x3 -> pc=3.
  - Opcode 111111 -> halted=1 after DECODE; no further imem_req; pc frozen.
  - reset pulsed mid MEM_RD wait -> dmem_req drops immediately; pc=0 and instret=0; next fetch starts at addr 0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared ISA constants, FSM state and ALU operation encodings for mc_cpu.
package mc_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD,
        MEM_WB, MEM_WR, BRANCH, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic logic funct_valid(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/mc_cpu_if.sv
// Instruction and data memory request/ready buses of mc_cpu.
interface mc_cpu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mc_cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, R0 reads zero.
module mc_regfile #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next register contents: writes to R0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports.
    always_comb begin
        rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
        rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
    end
endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle, non-pipelined MIPS-subset core.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    mc_cpu_if.master          bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       instret
);
    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [31:0]       instret_q, instret_d;

    logic [5:0]        opcode, funct;
    logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx;
    logic signed [15:0] imm16;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b, alu_y;
    logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [RIDX_W-1:0] rf_waddr;
    logic              rf_we, retire;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RIDX_W];
    assign rt_idx   = ir_q[16 +: RIDX_W];
    assign rd_idx   = ir_q[11 +: RIDX_W];
    assign imm16    = ir_q[15:0];
    assign imm_data = DATA_W'(imm16);
    assign imm_addr = ADDR_W'(imm16);

    mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus.imem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = funct_valid(funct) ? EXEC : HALT;
                    OP_ADDI:      state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default:      state_d = HALT;
                endcase
            end
            EXEC:     state_d = ALU_WB;
            ALU_WB:   state_d = FETCH;
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (bus.dmem_ready) state_d = MEM_WB;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   if (bus.dmem_ready) state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    // FSM outputs: bus requests, register write enable, retire strobe.
    // imem_req is gated by reset so no request is visible while reset is held.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        case (state_q)
            FETCH:  bus.imem_req = ~reset;
            MEM_RD: bus.dmem_req = 1'b1;
            MEM_WR: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = 1'b1;
                retire       = bus.dmem_ready;
            end
            ALU_WB, MEM_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            BRANCH, JUMP: retire = 1'b1;
            default: ;
        endcase
    end

    // ALU operation select and evaluation.
    always_comb begin
        alu_op = ALU_ADD;
        if ((state_q == EXEC) && (opcode == OP_RTYPE)) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
        alu_b = (opcode == OP_RTYPE) ? b_q : imm_data;
        case (alu_op)
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SLT: alu_y = DATA_W'($signed(a_q) < $signed(alu_b));
            default: alu_y = a_q + alu_b;
        endcase
    end

    // Datapath register updates per state.
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ready) begin
                    ir_d = bus.imem_rdata;
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            DECODE: begin
                a_d = rf_rdata_a;
                b_d = rf_rdata_b;
            end
            EXEC, MEM_ADDR: alu_out_d = alu_y;
            MEM_RD:  if (bus.dmem_ready) mdr_d = bus.dmem_rdata;
            BRANCH:  if (a_q == b_q) pc_d = pc_q + imm_addr;
            JUMP:    pc_d = ADDR_W'(ir_q[25:0]);
            default: ;
        endcase
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    // Write-back selection and bus data outputs.
    always_comb begin
        rf_waddr       = ((state_q == ALU_WB) && (opcode == OP_RTYPE)) ? rd_idx : rt_idx;
        rf_wdata       = (state_q == MEM_WB) ? mdr_q : alu_out_q;
        bus.imem_addr  = pc_q;
        bus.dmem_addr  = ADDR_W'(alu_out_q);
        bus.dmem_wdata = b_q;
        pc             = pc_q;
        instret        = instret_q;
        halted         = (state_q == HALT);
    end
endmodule

// File: tb/tb_mc_cpu.sv
// Scoreboard bench for mc_cpu: ISA-level reference model vs. observed bus traffic.
module tb_mc_cpu;
    localparam int DW = 32;
    localparam int AW = 16;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } mem_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [AW-1:0] pc;
    logic halted;
    logic [31:0] instret;

    always #5 clk = ~clk;

    mc_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mc_cpu #(.DATA_W(DW), .ADDR_W(AW), .NREG(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .instret (instret)
    );

    logic [31:0] prog [64];
    logic [31:0] dut_dmem [65536];
    logic [31:0] ref_dmem [65536];
    logic [15:0] fetch_q [$];
    mem_t        mem_q [$];

    int tests = 0;
    int fails = 0;
    int waits = 0;
    int dwait_fixed = -1;
    bit rand_ready = 1'b0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'b000010, 26'(tgt)};
    endfunction

    // Memory responder: random or fixed wait states per request, counts wait cycles.
    bit in_req = 1'b0;
    int wait_left = 0;
    logic rdy;
    initial begin
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_rdata = '0;
    end
    always @(negedge clk) begin
        bus.imem_rdata = prog[bus.imem_addr[5:0]];
        bus.dmem_rdata = dut_dmem[bus.dmem_addr];
        rdy = 1'b0;
        if (reset || !(bus.imem_req || bus.dmem_req)) begin
            in_req = 1'b0;
        end else begin
            if (!in_req) begin
                in_req = 1'b1;
                if (bus.dmem_req && dwait_fixed >= 0) wait_left = dwait_fixed;
                else if (rand_ready) wait_left = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                else wait_left = 0;
            end
            if (wait_left == 0) begin
                rdy = 1'b1;
                in_req = 1'b0;
                if (bus.dmem_req && bus.dmem_we) dut_dmem[bus.dmem_addr] = bus.dmem_wdata;
            end else begin
                wait_left--;
                waits++;
            end
        end
        bus.imem_ready = rdy;
        bus.dmem_ready = rdy;
    end

    // Monitor: pops expectations on each accepted handshake, checks held requests stay stable.
    bit hold_d = 1'b0, hold_i = 1'b0;
    logic [AW+DW:0] hold_dv;
    logic [AW-1:0]  hold_ia;
    always begin
        @(negedge clk);
        #1;
        if (mon_en && !reset) begin
            if (hold_d) chk("dmem_hold_stable", {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, {1'b1, hold_dv});
            if (hold_i) chk("imem_hold_stable", {bus.imem_req, bus.imem_addr}, {1'b1, hold_ia});
            hold_d  = bus.dmem_req && !bus.dmem_ready;
            hold_dv = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
            hold_i  = bus.imem_req && !bus.imem_ready;
            hold_ia = bus.imem_addr;
            if ((bus.imem_req && bus.imem_ready) || (bus.dmem_req && bus.dmem_ready))
                chk("req_exclusive", bus.imem_req & bus.dmem_req, 1'b0);
            if (bus.imem_req && bus.imem_ready) begin
                if (fetch_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fetch_extra: got fetch at %0h expected none", bus.imem_addr);
                end else begin
                    chk("fetch_addr", bus.imem_addr, fetch_q.pop_front());
                end
            end
            if (bus.dmem_req && bus.dmem_ready) begin
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dmem_extra: got access at %0h expected none", bus.dmem_addr);
                end else begin
                    mem_t e;
                    e = mem_q.pop_front();
                    chk("dmem_we", bus.dmem_we, e.we);
                    chk("dmem_addr", bus.dmem_addr, e.addr);
                    if (e.we) chk("dmem_wdata", bus.dmem_wdata, e.data);
                end
            end
        end else begin
            hold_d = 1'b0;
            hold_i = 1'b0;
        end
    end

    // Instruction-level reference model: executes n instructions, queues expected traffic.
    task automatic ref_run(input int n, output int cyc, output bit hlt, output logic [15:0] fpc, output int ret);
        logic [31:0] r [32];
        logic [15:0] rpc, ea;
        logic [31:0] ins, a, b, imm, res, sum;
        int dst, c;
        bit wr;
        foreach (r[i]) r[i] = '0;
        rpc = '0; cyc = 0; hlt = 1'b0; ret = 0;
        for (int k = 0; k < n; k++) begin
            fetch_q.push_back(rpc);
            ins = prog[rpc[5:0]];
            rpc = rpc + 16'd1;
            a = r[ins[25:21]];
            b = r[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            sum = a + imm;
            ea = sum[15:0];
            wr = 1'b0; dst = 0; res = '0; c = 0;
            case (ins[31:26])
                6'h00: begin
                    wr = 1'b1; dst = int'(ins[15:11]); c = 4;
                    case (ins[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: hlt = 1'b1;
                    endcase
                end
                6'h08: begin wr = 1'b1; dst = int'(ins[20:16]); res = sum; c = 4; end
                6'h23: begin
                    mem_q.push_back('{we: 1'b0, addr: ea, data: 32'h0});
                    wr = 1'b1; dst = int'(ins[20:16]); res = ref_dmem[ea]; c = 5;
                end
                6'h2B: begin
                    mem_q.push_back('{we: 1'b1, addr: ea, data: b});
                    ref_dmem[ea] = b; c = 4;
                end
                6'h04: begin if (a == b) rpc = rpc + imm[15:0]; c = 3; end
                6'h02: begin rpc = ins[15:0]; c = 3; end
                default: hlt = 1'b1;
            endcase
            if (hlt) begin
                cyc += 2;
                break;
            end
            cyc += c;
            ret++;
            if (wr && dst != 0) r[dst] = res;
        end
        fpc = rpc;
    endtask

    task automatic run_prog(input string tag, input int n, input bit rr, input int dw, input bit chk12);
        int exp_cyc, exp_ret, cyc;
        bit exp_halt;
        logic [15:0] exp_pc, pc_hold;
        mon_en = 1'b0;
        reset = 1'b1;
        fetch_q.delete();
        mem_q.delete();
        for (int i = 0; i < 65536; i++) begin
            dut_dmem[i] = (i * 32'h9E3779B9) ^ 32'h0000_1234;
            ref_dmem[i] = dut_dmem[i];
        end
        @(posedge clk);
        #1;
        chk({tag, "_rst_state"}, {pc, instret, halted, bus.imem_req, bus.dmem_req}, '0);
        ref_run(n, exp_cyc, exp_halt, exp_pc, exp_ret);
        rand_ready = rr;
        dwait_fixed = dw;
        waits = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk12 && cyc == 12) chk({tag, "_instret_at_12"}, instret, 32'd3);
            if (halted || (!exp_halt && instret == 32'(exp_ret))) break;
        end
        chk({tag, "_cycles"}, cyc, exp_cyc + waits);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_instret"}, instret, 32'(exp_ret));
        chk({tag, "_halted"}, halted, exp_halt);
        if (exp_halt) begin
            pc_hold = pc;
            repeat (10) begin
                @(posedge clk);
                #1;
                chk({tag, "_halt_frozen"}, {bus.imem_req, bus.dmem_req, halted, pc, instret},
                    {1'b0, 1'b0, 1'b1, pc_hold, 32'(exp_ret)});
            end
        end
        chk({tag, "_fetch_q_left"}, fetch_q.size(), 0);
        chk({tag, "_mem_q_left"}, mem_q.size(), 0);
        mon_en = 1'b0;
        reset = 1'b1;
    endtask

    task automatic fill_nops();
        foreach (prog[i]) prog[i] = enc_r(0, 0, 0, 6'h20);
    endtask

    task automatic reset_mid_test();
        int k;
        fill_nops();
        prog[0] = enc_i(6'h08, 0, 1, 1);
        prog[1] = enc_i(6'h23, 0, 2, 0);
        mon_en = 1'b0;
        rand_ready = 1'b0;
        dwait_fixed = 20;
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        k = 0;
        while (!bus.dmem_req && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rmid_reach_mem_rd", bus.dmem_req, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rmid_before", {bus.dmem_req, pc, instret}, {1'b1, 16'd2, 32'd1});
        #2 reset = 1'b1;
        #1;
        chk("rmid_reqs_drop", {bus.imem_req, bus.dmem_req}, 2'b00);
        chk("rmid_pc_instret", {pc, instret}, '0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rmid_first_fetch", {bus.imem_req, bus.imem_addr}, {1'b1, 16'd0});
        @(posedge clk);
        reset = 1'b1;
        dwait_fixed = -1;
    endtask

    task automatic gen_random_prog();
        int rs, rt;
        foreach (prog[i]) begin
            rs = int'($urandom_range(0, 7));
            rt = int'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: prog[i] = enc_r(rs, rt, int'($urandom_range(0, 7)), 6'h20);
                1: prog[i] = enc_r(rs, rt, int'($urandom_range(0, 7)), 6'h22);
                2: prog[i] = enc_r(rs, rt, int'($urandom_range(0, 7)), 6'h24);
                3: prog[i] = enc_r(rs, rt, int'($urandom_range(0, 7)), 6'h25);
                4: prog[i] = enc_r(rs, rt, int'($urandom_range(0, 7)), 6'h2A);
                5: prog[i] = enc_i(6'h08, rs, rt, int'($urandom));
                6: prog[i] = enc_i(6'h23, rs, rt, int'($urandom));
                7: prog[i] = enc_i(6'h2B, rs, rt, int'($urandom));
                8: prog[i] = enc_i(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt, int'($urandom_range(0, 8)) - 4);
                default: prog[i] = enc_j(int'($urandom));
            endcase
        end
    endtask

    initial begin
        fill_nops();
        prog[0]  = enc_i(6'h08, 0, 1, 5);
        prog[1]  = enc_i(6'h08, 0, 2, -3);
        prog[2]  = enc_r(1, 2, 3, 6'h20);
        prog[3]  = enc_i(6'h2B, 0, 3, 8);
        prog[4]  = enc_i(6'h2B, 0, 1, 4);
        prog[5]  = enc_i(6'h23, 0, 4, 4);
        prog[6]  = enc_i(6'h2B, 0, 4, 9);
        prog[7]  = enc_i(6'h04, 1, 2, 5);
        prog[8]  = enc_j(10);
        prog[9]  = 32'hFC00_0000;
        prog[10] = enc_r(2, 1, 6, 6'h2A);
        prog[11] = enc_i(6'h2B, 0, 6, 10);
        prog[12] = enc_i(6'h04, 1, 1, -1);
        run_prog("dirA", 16, 1'b0, -1, 1'b1);
        run_prog("dirA_dwait3", 16, 1'b0, 3, 1'b0);
        run_prog("dirA_rnd", 16, 1'b1, -1, 1'b0);

        fill_nops();
        prog[0] = enc_i(6'h08, 0, 1, 1);
        prog[1] = 32'hFC00_0000;
        run_prog("halt_op", 5, 1'b0, -1, 1'b0);
        prog[1] = enc_r(1, 1, 2, 6'h3F);
        run_prog("halt_fn", 5, 1'b1, -1, 1'b0);

        reset_mid_test();

        for (int s = 0; s < 4; s++) begin
            gen_random_prog();
            run_prog("rnd", 200, 1'b1, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
